// File: rtl/multiplier_seq_ctrl.sv
// Sequential shift-add multiplier: one partial product per clock over WIDTH clocks,
// with valid/ready handshakes on the operand and result sides.
module multiplier_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [WIDTH-1:0] a_r;
    logic [PW-1:0]   b_r;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   result_r;
    logic [PW-1:0]   acc_sum_s;
    logic [CW-1:0]   count_r;
    logic            accept_s;
    logic            last_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic            busy_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    // Multiplicand shifted into position when the scanned multiplier bit is set.
    function automatic logic [PW-1:0] partial_product(
        input logic          bit_sel,
        input logic [PW-1:0] mcand,
        input logic [CW-1:0] shamt
    );
        if (bit_sel) begin
            return mcand << shamt;
        end else begin
            return {PW{1'b0}};
        end
    endfunction

    assign accept_s  = (state_r == IDLE) && in_valid && in_ready_r;
    assign last_s    = (state_r == RUN) && (count_r == LAST_BIT);
    assign acc_sum_s = acc_r + partial_product(a_r[count_r], b_r, count_r);

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (count_r == LAST_BIT) state_s = DONE;
                else                     state_s = RUN;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode on the upcoming state so the registered outputs track the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_s)
            IDLE: begin
                in_ready_s = 1'b1;
            end
            RUN: begin
                busy_s = 1'b1;
            end
            DONE: begin
                busy_s      = 1'b1;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Operand capture, accumulation and result register; result persists after the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {PW{1'b0}};
            acc_r    <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            result_r <= {PW{1'b0}};
        end else if (accept_s) begin
            a_r     <= in1;
            b_r     <= {{WIDTH{1'b0}}, in2};
            acc_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            acc_r <= acc_sum_s;
            if (last_s) begin
                result_r <= acc_sum_s;
                count_r  <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = result_r;

endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// Scoreboard bench for multiplier_seq_ctrl: accepted operand pairs queue an expected
// product; a monitor pops and compares on every result transfer.
module tb_multiplier_seq_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in1 = '0;
    logic [W-1:0]   in2 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_acc = -1;
    bit b2b = 1'b0;
    logic [2*W-1:0] exp_q[$];
    int             t_q[$];

    multiplier_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int n;
        n = 0;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (in_ready) tick();
        else          fail("accept_timeout");
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
    endtask

    // Accept observer: expected product computed from the operands at the accepting edge.
    initial forever begin
        @(posedge clk);
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(in1, in2));
            t_q.push_back(cyc);
            if (b2b && last_acc >= 0) check("accept_gap", cyc - last_acc, W + 2);
            last_acc = cyc;
        end
    end

    // Result monitor: latency on the rising edge of out_valid, product on each transfer.
    initial begin
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_v) begin
                    if (t_q.size() == 0) fail("unexpected_valid");
                    else                 check("latency", cyc - t_q[0], W);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("spurious_transfer");
                    end else begin
                        check("product", out, exp_q.pop_front());
                        if (t_q.size() != 0) void'(t_q.pop_front());
                    end
                end
            end
            prev_v = out_valid;
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        ta = '{8'd255, 8'd0, 8'd1, 8'd128};
        tb = '{8'd255, 8'd200, 8'd255, 8'd2};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);
        tick();

        // 13*11 with status during RUN
        out_ready = 1'b1;
        do_op(8'd13, 8'd11, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            check("run_out_valid", out_valid, 0);
        end
        @(negedge clk);
        check("done_valid_13x11", out_valid, 1);
        check("done_out_13x11", out, 143);
        drain();

        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1'b0);
            drain();
        end

        // backpressure
        out_ready = 1'b0;
        do_op(8'd6, 8'd7, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) fail("bp_valid_timeout");
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out", out, 42);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_valid_drop", out_valid, 0);
        check("bp_out_kept", out, 42);
        check("bp_idle_ready", in_ready, 1);
        drain();

        // request during RUN is ignored
        do_op(8'd5, 8'd5, 1'b0);
        in1 = 8'd3;
        in2 = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ignore_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        do_op(8'd3, 8'd3, 1'b0);
        drain();

        // asynchronous reset mid-RUN
        do_op(8'd200, 8'd100, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out", out, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        exp_q.delete();
        t_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(8'd2, 8'd3, 1'b0);
        drain();
        check("after_abort_out", out, 6);

        // back-to-back random
        b2b = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 50; i++) begin
            do_op(W'($urandom), W'($urandom), 1'b1);
        end
        in_valid = 1'b0;
        b2b = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
